// File: rtl/simon_pkg.sv
// Shared types for the Simon-style game datapath: colour encoding, the
// sequence-player state set, and the colour-to-LED decode.
package simon_pkg;

    localparam int NUM_COLORS = 4;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAUSE    = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_t;

    // One-hot LED pattern for a colour (bit i lights colour i).
    function automatic logic [NUM_COLORS-1:0] onehot(input color_t c);
        logic [NUM_COLORS-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sequence_player_press_detect.sv
// Button press detector: keeps last cycle's button vector and reports rising
// edges on the current vector. A single rising bit is a press of that colour;
// two or more rising in the same cycle is flagged separately. The previous
// value register updates every cycle regardless of who consumes the result,
// so a button already held when the consumer starts listening is not a press.
module press_detect
    import simon_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COLORS-1:0] buttons,
    output logic                  press_valid,
    output color_t                press_color,
    output logic                  multi_press
);

    logic [NUM_COLORS-1:0] prev_q, prev_d;
    logic [NUM_COLORS-1:0] rise;
    logic [2:0]            rise_cnt;

    // Previous-value register always tracks the live buttons.
    always_comb begin
        prev_d = buttons;
    end

    // Edge-history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Rising-edge decode: count of new bits and the colour of the (single) new bit.
    always_comb begin
        rise        = buttons & ~prev_q;
        rise_cnt    = '0;
        press_color = '0;
        for (int i = 0; i < NUM_COLORS; i++) begin
            rise_cnt = rise_cnt + {2'b00, rise[i]};
            if (rise[i]) begin
                press_color = i[1:0];
            end
        end
        press_valid = (rise_cnt == 3'd1);
        multi_press = (rise_cnt > 3'd1);
    end

endmodule

// File: rtl/sequence_player.sv
// Simon sequence player: plays the first `round` colours of the generator's
// sequence on the LEDs, then checks the player's presses against them, growing
// the round by one after each fully matched round until SEQ_LEN is reached.
// Optional build macro SEQ_PLAYER_TIMEOUT_EN adds a per-press idle timeout
// (INPUT_TIMEOUT cycles) in the input phase; without it the input phase waits
// indefinitely.
module sequence_player
    import simon_pkg::*;
#(
    parameter int SEQ_LEN       = 100,
    parameter int SHOW_CYCLES   = 25_000_000,
    parameter int GAP_CYCLES    = 12_000_000,
    parameter int INPUT_TIMEOUT = 250_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  color_t [SEQ_LEN-1:0]  game_sequence,
    input  logic                  go,
    input  logic [NUM_COLORS-1:0] buttons,
    output logic                  seq_freeze,
    output logic [NUM_COLORS-1:0] led,
    output logic [6:0]            round,
    output logic                  playing,
    output logic                  win,
    output logic                  lose
);

    localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int PH_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMR_W  = $clog2(PH_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [6:0]       ROUND_MAX = 7'(SEQ_LEN);

    // Reject parameter sets the counters cannot represent.
    if (SEQ_LEN < 1 || SEQ_LEN > 127 || SHOW_CYCLES < 1 || GAP_CYCLES < 1 ||
        INPUT_TIMEOUT < 1) begin : g_cfg_check
        $error("sequence_player: invalid parameter set");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         round_q, round_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic   press_valid;
    logic   multi_press;
    color_t press_color;
    logic   last_idx;
    logic   timeout_hit;

    press_detect u_press_detect (
        .clk         (clk),
        .reset       (reset),
        .buttons     (buttons),
        .press_valid (press_valid),
        .press_color (press_color),
        .multi_press (multi_press)
    );

    // idx points at the final entry of the current round.
    always_comb begin
        last_idx = (7'(idx_q) == (round_q - 7'd1));
    end

`ifdef SEQ_PLAYER_TIMEOUT_EN
    localparam int TO_W = $clog2(INPUT_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(INPUT_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Idle counter: runs only while staying in WAIT_IN with no single press;
    // any state change or accepted press restarts it.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_WAIT_IN && state_d == ST_WAIT_IN && !press_valid) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end
        timeout_hit = (state_q == ST_WAIT_IN) && (to_cnt_q == TO_LAST);
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // No timeout: the input phase waits for the player forever.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Next-state, entry index and round length.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (go) begin
                    state_d = ST_PAUSE;
                    round_d = 7'd1;
                    idx_d   = '0;
                end
            end
            ST_PAUSE: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = ST_SHOW_ON;
                end
            end
            ST_SHOW_ON: begin
                if (tmr_q == SHOW_LAST) begin
                    state_d = ST_SHOW_OFF;
                end
            end
            ST_SHOW_OFF: begin
                if (tmr_q == GAP_LAST) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_SHOW_ON;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (multi_press) begin
                    state_d = ST_LOSE;
                end else if (press_valid) begin
                    if (press_color != game_sequence[idx_q]) begin
                        state_d = ST_LOSE;
                    end else if (!last_idx) begin
                        idx_d = idx_q + IDX_ONE;
                    end else if (round_q == ROUND_MAX) begin
                        state_d = ST_WIN;
                    end else begin
                        round_d = round_q + 7'd1;
                        idx_d   = '0;
                        state_d = ST_PAUSE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_LOSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase timer: counts inside the timed phases, cleared on any state change.
    always_comb begin
        tmr_d = '0;
        if (state_d == state_q &&
            (state_q == ST_PAUSE || state_q == ST_SHOW_ON || state_q == ST_SHOW_OFF)) begin
            tmr_d = tmr_q + TMR_ONE;
        end
    end

    // State, index, round and timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            round_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            tmr_q   <= tmr_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        seq_freeze = 1'b0;
        led        = '0;
        playing    = 1'b0;
        win        = 1'b0;
        lose       = 1'b0;
        round      = round_q;
        case (state_q)
            ST_PAUSE: begin
                seq_freeze = 1'b1;
                playing    = 1'b1;
            end
            ST_SHOW_ON: begin
                seq_freeze = 1'b1;
                playing    = 1'b1;
                led        = onehot(game_sequence[idx_q]);
            end
            ST_SHOW_OFF: begin
                seq_freeze = 1'b1;
                playing    = 1'b1;
            end
            ST_WAIT_IN: begin
                seq_freeze = 1'b1;
                led        = buttons;
            end
            ST_WIN: begin
                led = '1;
                win = 1'b1;
            end
            ST_LOSE: begin
                lose = 1'b1;
            end
            default: begin
                seq_freeze = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player with SEQ_LEN=4, SHOW=3, GAP=2, TIMEOUT=10.
// Expected LED playback colours and end-of-game outcomes are queued by the
// driver from the game rules; a negedge monitor pops and compares them.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int SEQ_LEN = 4;
    localparam int SHOW    = 3;
    localparam int GAP     = 2;
    localparam int TMO     = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 go = 1'b0;
    logic [3:0]           buttons = 4'b0;
    color_t [SEQ_LEN-1:0] game_sequence;
    logic                 seq_freeze, playing, win, lose;
    logic [3:0]           led;
    logic [6:0]           round;

    sequence_player #(
        .SEQ_LEN       (SEQ_LEN),
        .SHOW_CYCLES   (SHOW),
        .GAP_CYCLES    (GAP),
        .INPUT_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .game_sequence (game_sequence),
        .go            (go),
        .buttons       (buttons),
        .seq_freeze    (seq_freeze),
        .led           (led),
        .round         (round),
        .playing       (playing),
        .win           (win),
        .lose          (lose)
    );

    // Clock.
    always #5 clk = ~clk;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [3:0]  exp_show_q[$];
    logic [13:0] exp_out_q[$];   // {win, lose, seq_freeze, round[6:0], led[3:0]}
    bit         mon_en = 1'b0;
    color_t     seq_m[SEQ_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: playback timing/colours and game outcomes.
    initial begin : monitor
        int dark_run, show_run;
        bit prev_play, prev_end;
        logic [3:0]  e;
        logic [13:0] eo;
        dark_run = 0; show_run = 0; prev_play = 0; prev_end = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                dark_run = 0; show_run = 0; prev_play = 0; prev_end = 0;
            end else begin
                if (playing) begin
                    if (led == 4'b0) begin
                        if (show_run > 0) begin
                            check("show_len", show_run, SHOW);
                            show_run = 0;
                        end
                        dark_run++;
                    end else begin
                        if (show_run == 0) begin
                            check("gap_len", dark_run, GAP);
                            dark_run = 0;
                            if (exp_show_q.size() == 0) check("show_unexpected", led, 0);
                            else begin
                                e = exp_show_q.pop_front();
                                check("show_color", led, e);
                            end
                        end
                        show_run++;
                    end
                end else begin
                    if (prev_play) begin
                        check("final_gap", dark_run, GAP);
                        check("show_open", show_run, 0);
                    end
                    dark_run = 0; show_run = 0;
                end
                if ((win || lose) && !prev_end) begin
                    if (exp_out_q.size() == 0) check("outcome_unexpected", {win, lose}, 0);
                    else begin
                        eo = exp_out_q.pop_front();
                        check("outcome", {win, lose, seq_freeze, round, led}, eo);
                    end
                end
                prev_play = playing;
                prev_end  = win || lose;
            end
        end
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic push_shows(input int r);
        for (int i = 0; i < r; i++) exp_show_q.push_back(onehot(seq_m[i]));
    endtask

    task automatic drive_press(input logic [3:0] v);
        @(posedge clk); #1 buttons = v;
        @(posedge clk); #1 buttons = 4'b0;
    endtask

    task automatic wait_wait_in();
        int n;
        n = 0;
        @(negedge clk);
        while (playing && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_in", {win, lose, playing}, 3'b000);
    endtask

    task automatic wait_show();
        int n;
        n = 0;
        @(negedge clk);
        while (!(playing && led != 4'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_show", {playing, (led != 4'b0)}, 2'b11);
    endtask

    task automatic play_start(input logic [7:0] bits);
        for (int i = 0; i < SEQ_LEN; i++) begin
            seq_m[i]         = bits[2*i +: 2];
            game_sequence[i] = bits[2*i +: 2];
        end
        push_shows(1);
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        check("go_accept", {seq_freeze, playing, round}, {1'b1, 1'b1, 7'd1});
    endtask

    // kind: 0 = play to win, 1 = wrong colour at (lose_r, lose_p), 2 = two buttons at once.
    task automatic play_game(input logic [7:0] bits, input int lose_r, input int lose_p,
                             input int kind, input color_t wrong);
        logic [3:0] v;
        play_start(bits);
        for (int r = 1; r <= SEQ_LEN; r++) begin
            wait_wait_in();
            check("round_len", round, r);
            for (int p = 0; p < r; p++) begin
                if (kind != 0 && r == lose_r && p == lose_p) begin
                    v = (kind == 2) ? 4'b0101 : onehot(wrong);
                    exp_out_q.push_back({1'b0, 1'b1, 1'b0, 7'(r), 4'b0000});
                    drive_press(v);
                    @(negedge clk);
                    check("lose_now", {win, lose}, 2'b01);
                    return;
                end
                if (p == r - 1) begin
                    if (r == SEQ_LEN) exp_out_q.push_back({1'b1, 1'b0, 1'b0, 7'(r), 4'hf});
                    else push_shows(r + 1);
                end
                drive_press(onehot(seq_m[p]));
                @(negedge clk);
                if (p < r - 1) check("stay_wait_in", {win, lose, playing}, 3'b000);
                else if (r < SEQ_LEN) check("next_round", {playing, round}, {1'b1, 7'(r + 1)});
                else check("win_now", {win, lose, led}, {2'b10, 4'hf});
            end
        end
    endtask

    task automatic held_and_reset(input logic [7:0] bits);
        color_t w;
        play_start(bits);
        w = seq_m[0] + 2'd1;
        wait_show();
        @(posedge clk); #1 buttons = onehot(w);
        wait_wait_in();
        repeat (4) @(negedge clk);
        check("held_no_press", {win, lose, playing, led}, {3'b000, onehot(w)});
        @(posedge clk); #1 buttons = 4'b0;
        push_shows(2);
        drive_press(onehot(seq_m[0]));
        @(negedge clk);
        check("held_then_press", {playing, round}, {1'b1, 7'd2});
        wait_show();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        check("go_ignored", {playing, seq_freeze, round}, {2'b11, 7'd2});
        wait_show();
        mon_en = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_show", {seq_freeze, playing, win, lose, led, round}, 0);
        exp_show_q.delete();
        mon_en = 1'b1;
    endtask

    // Stimulus.
    initial begin
        logic [7:0] bits;
        int         kind, lr, lp;
        color_t     wc;
        game_sequence = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", {seq_freeze, playing, win, lose, led, round}, 0);
        mon_en = 1'b1;

        // seq = {2,0,3,1}: full win, wrong colour in round 2, double press.
        play_game(8'b01_11_00_10, 0, 0, 0, 2'd0);
        play_game(8'b01_11_00_10, 2, 1, 1, 2'd1);
        play_game(8'b01_11_00_10, 3, 0, 2, 2'd0);
        held_and_reset(8'b01_11_00_10);

`ifdef SEQ_PLAYER_TIMEOUT_EN
        play_start(8'b01_11_00_10);
        wait_wait_in();
        push_shows(2);
        drive_press(onehot(seq_m[0]));
        @(negedge clk);
        check("next_round", {playing, round}, {1'b1, 7'd2});
        wait_wait_in();
        repeat (7) @(negedge clk);
        drive_press(onehot(seq_m[0]));
        @(negedge clk);
        check("press_at_9", {win, lose, playing}, 3'b000);
        repeat (9) @(negedge clk);
        check("timeout_not_yet", {win, lose, playing}, 3'b000);
        exp_out_q.push_back({1'b0, 1'b1, 1'b0, 7'd2, 4'b0000});
        @(negedge clk);
        check("timeout_lose", {win, lose}, 2'b01);
`else
        play_start(8'b01_11_00_10);
        wait_wait_in();
        repeat (1000) @(negedge clk);
        check("idle_1000", {win, lose, playing, seq_freeze, round}, {4'b0001, 7'd1});
        exp_out_q.push_back({1'b0, 1'b1, 1'b0, 7'd1, 4'b0000});
        drive_press(onehot(seq_m[0] + 2'd1));
        @(negedge clk);
        check("lose_after_idle", {win, lose}, 2'b01);
`endif

        for (int g = 0; g < 12; g++) begin
            bits = 8'($urandom);
            kind = $urandom_range(0, 2);
            lr   = $urandom_range(1, SEQ_LEN);
            lp   = $urandom_range(0, lr - 1);
            wc   = color_t'(bits[2*lp +: 2] + 2'($urandom_range(1, 3)));
            play_game(bits, lr, lp, kind, wc);
        end

        repeat (2) @(negedge clk);
        check("queues_drained", exp_show_q.size() + exp_out_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
